sequenciador_multiciclo: RTL and testbench
==========================================

Name: sequenciador_multiciclo

Overview:
Parametrised multicycle control sequencer for the single-issue RISC-V datapath. It steps each instruction through IF, ID, EX, MEM, WB and SUMPC, and issues one-hot phase enables to the datapath sub-blocks. Delay slots are set by parameters, MEM waits on a ready handshake, and there is a single-step debug mode. It halts on a configurable halt word and exposes saturating cycle and instruction counters for the display block.

Parameters:
EX_WAIT, 2, extra wait cycles after EX before MEM; legal range 0..15.
WB_WAIT, 3, extra wait cycles after WB before SUMPC, also used as the display-settle time on halt; legal range 0..15.
CNT_W, 16, width of cycle_count and instr_count.
HALT_INSTR, 32'h0000_0000, instruction word that ends execution.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  reset, asynchronous, active-low.
instrucao  in  32  current instruction word from instruction memory; valid from ID onward.
mem_ready  in  1  data memory done; sampled only in MEM.
step_en  in  1  1 = single-step mode.
step_req  in  1  advance request while in PAUSE.
estado  out  4  current state code.
if_en, id_en, ex_en, mem_en, wb_en, pc_en  out  1 each  phase enables.
final  out  1  execution finished.
busy  out  1  1 unless in FIM or PAUSE.
cycle_count  out  CNT_W  cycles since reset, excluding FIM.
instr_count  out  CNT_W  instructions retired.

Behaviour:
- Reset (rst=0, async): estado=IF, wait counter=0, halt_pend=0, both counters=0, final=0. Releasing reset starts IF on the next edge.
- State codes: IF=0, ID=1, EX=2, EX_W=3, MEM=4, WB=5, WB_W=6, SUMPC=7, PAUSE=8, FIM=9. Codes 10..15 go to IF on the next edge.
- Transitions:
  - IF -> ID.
  - ID -> EX if instrucao != HALT_INSTR. Otherwise set halt_pend=1 and go to WB_W, or directly to FIM if WB_WAIT=0.
  - EX -> EX_W, or -> MEM if EX_WAIT=0.
  - EX_W holds EX_WAIT cycles, then -> MEM.
  - MEM holds while mem_ready=0; -> WB on the edge where mem_ready=1.
  - WB -> WB_W, or -> SUMPC if WB_WAIT=0.
  - WB_W holds WB_WAIT cycles, then -> FIM if halt_pend, else -> SUMPC.
  - SUMPC -> PAUSE if step_en=1, else -> IF.
  - PAUSE -> IF when step_req=1 or step_en=0; otherwise hold.
  - FIM is terminal; only reset leaves it.
- Wait counter:
  - 4 bits, loaded with N-1 on entry to a wait state.
  - Decrements each cycle; the wait state exits when the counter is 0.
- Outputs, all decoded from the registered state with no combinational path from inputs:
  - Each *_en is high exactly while estado equals the matching state: if_en=IF, id_en=ID, ex_en=EX, mem_en=MEM, wb_en=WB, pc_en=SUMPC.
  - final=1 iff estado=FIM.
- Counters:
  - cycle_count increments on every edge where estado != FIM.
  - instr_count increments on every edge where estado = SUMPC.
  - Both saturate at all-ones and never wrap.
  - The halt word is not counted as an instruction.
- Boundary cases:
  - mem_ready=1 already on MEM entry: MEM lasts 1 cycle.
  - step_en changes mid-instruction: it takes effect only at SUMPC.
  - step_req outside PAUSE: ignored.
  - Reset asserted mid-state or mid-wait: immediate return to the reset state, counters cleared.
- Default cycle cost with mem_ready=1: 11 cycles per instruction (IF, ID, EX, 2×EX_W, MEM, WB, 3×WB_W, SUMPC).

Decomposition:
- Package pacote_controle holds:
  - the 4-bit state-code localparams,
  - the state width constant,
  - the wait-counter width (4).
- One sub-module: contador_saturado. Parameter W; ports clk, rst, inc, q. It is instantiated twice, once for cycle_count and once for instr_count.

Test Plan:
- Defaults, one nonzero instruction, then 0, mem_ready=1 -> instr_count=1; FIM reached 16 cycles after reset release; final=1 from that cycle; cycle_count frozen at 16.
- mem_ready low for 4 cycles on MEM entry -> mem_en high for 5 cycles; instruction cost 15 cycles; wb_en pulses once.
- EX_WAIT=0, WB_WAIT=0 -> sequence IF, ID, EX, MEM, WB, SUMPC, IF; 6 cycles per instruction; halt word goes ID->FIM directly.
- step_en=1 -> after SUMPC, estado=8 and busy=0; holds 10 cycles; step_req pulse for 1 cycle -> IF next cycle; instr_count unchanged by PAUSE.
- rst pulsed low asynchronously mid-EX_W -> estado=0 and counters=0 before the next clk edge; a fresh sequence runs afterward.
- CNT_W=4, 20 instructions -> instr_count saturates at 15 and cycle_count saturates at 15; the sequencer still reaches FIM normally.

Source files
------------

// File: rtl/sequenciador_multiciclo_pkg.sv
// State codes and widths shared by the multicycle sequencer and its helpers.
package pacote_controle;

    localparam int ESTADO_W = 4;
    localparam int ESPERA_W = 4;

    localparam logic [ESTADO_W-1:0] S_IF    = 4'd0;
    localparam logic [ESTADO_W-1:0] S_ID    = 4'd1;
    localparam logic [ESTADO_W-1:0] S_EX    = 4'd2;
    localparam logic [ESTADO_W-1:0] S_EX_W  = 4'd3;
    localparam logic [ESTADO_W-1:0] S_MEM   = 4'd4;
    localparam logic [ESTADO_W-1:0] S_WB    = 4'd5;
    localparam logic [ESTADO_W-1:0] S_WB_W  = 4'd6;
    localparam logic [ESTADO_W-1:0] S_SUMPC = 4'd7;
    localparam logic [ESTADO_W-1:0] S_PAUSE = 4'd8;
    localparam logic [ESTADO_W-1:0] S_FIM   = 4'd9;

endpackage

// File: rtl/sequenciador_multiciclo_contador_saturado.sv
// Up-counter that sticks at all-ones instead of wrapping.
module contador_saturado #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q
);

    // count on inc, hold once every bit is set
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/sequenciador_multiciclo.sv
// Multicycle control sequencer: steps each instruction through
// IF/ID/EX/MEM/WB/SUMPC and issues one-hot phase enables.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IF     | fetch
// ID     | decode; halt word detected here
// EX     | execute
// EX_W   | post-execute delay, EX_WAIT cycles
// MEM    | data memory access, held until mem_ready
// WB     | write-back
// WB_W   | post-write-back delay; also display settle time before FIM
// SUMPC  | PC update, instruction retired
// PAUSE  | single-step hold, waits for step_req or step_en=0
// FIM    | halted, only reset leaves
module sequenciador_multiciclo
    import pacote_controle::*;
#(
    parameter int          EX_WAIT    = 2,
    parameter int          WB_WAIT    = 3,
    parameter int          CNT_W      = 16,
    parameter logic [31:0] HALT_INSTR = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         instrucao,
    input  logic                mem_ready,
    input  logic                step_en,
    input  logic                step_req,
    output logic [ESTADO_W-1:0] estado,
    output logic                if_en,
    output logic                id_en,
    output logic                ex_en,
    output logic                mem_en,
    output logic                wb_en,
    output logic                pc_en,
    output logic                finalizado,
    output logic                busy,
    output logic [CNT_W-1:0]    cycle_count,
    output logic [CNT_W-1:0]    instr_count
);

    // Wait states exit when the down-counter reaches zero, so loading N-1
    // gives exactly N cycles in the wait state.
    localparam logic [ESPERA_W-1:0] EX_CARGA = ESPERA_W'(EX_WAIT - 1);
    localparam logic [ESPERA_W-1:0] WB_CARGA = ESPERA_W'(WB_WAIT - 1);

    logic [ESTADO_W-1:0] estado_prox;
    logic [ESPERA_W-1:0] espera, espera_prox;
    logic                halt_pend, halt_prox;

    // next-state, wait-counter and halt-pending decode
    always_comb begin
        estado_prox = estado;
        espera_prox = espera;
        halt_prox   = halt_pend;
        case (estado)
            S_IF: estado_prox = S_ID;
            S_ID: begin
                if (instrucao != HALT_INSTR) begin
                    estado_prox = S_EX;
                end else begin
                    halt_prox = 1'b1;
                    if (WB_WAIT == 0) begin
                        estado_prox = S_FIM;
                    end else begin
                        estado_prox = S_WB_W;
                        espera_prox = WB_CARGA;
                    end
                end
            end
            S_EX: begin
                if (EX_WAIT == 0) begin
                    estado_prox = S_MEM;
                end else begin
                    estado_prox = S_EX_W;
                    espera_prox = EX_CARGA;
                end
            end
            S_EX_W: begin
                if (espera == '0) estado_prox = S_MEM;
                else              espera_prox = espera - 4'd1;
            end
            S_MEM: begin
                if (mem_ready) estado_prox = S_WB;
            end
            S_WB: begin
                if (WB_WAIT == 0) begin
                    estado_prox = S_SUMPC;
                end else begin
                    estado_prox = S_WB_W;
                    espera_prox = WB_CARGA;
                end
            end
            S_WB_W: begin
                if (espera == '0) estado_prox = halt_pend ? S_FIM : S_SUMPC;
                else              espera_prox = espera - 4'd1;
            end
            S_SUMPC: estado_prox = step_en ? S_PAUSE : S_IF;
            S_PAUSE: begin
                if (step_req || !step_en) estado_prox = S_IF;
            end
            S_FIM:   estado_prox = S_FIM;
            default: estado_prox = S_IF;
        endcase
    end

    // state, wait counter and halt flag registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            estado    <= S_IF;
            espera    <= '0;
            halt_pend <= 1'b0;
        end else begin
            estado    <= estado_prox;
            espera    <= espera_prox;
            halt_pend <= halt_prox;
        end
    end

    assign if_en      = (estado == S_IF);
    assign id_en      = (estado == S_ID);
    assign ex_en      = (estado == S_EX);
    assign mem_en     = (estado == S_MEM);
    assign wb_en      = (estado == S_WB);
    assign pc_en      = (estado == S_SUMPC);
    assign finalizado = (estado == S_FIM);
    assign busy       = !((estado == S_FIM) || (estado == S_PAUSE));

    contador_saturado #(.W(CNT_W)) u_ciclos (
        .clk (clk),
        .rst (rst),
        .inc (estado != S_FIM),
        .q   (cycle_count)
    );

    contador_saturado #(.W(CNT_W)) u_instrs (
        .clk (clk),
        .rst (rst),
        .inc (estado == S_SUMPC),
        .q   (instr_count)
    );

endmodule

// File: tb/tb_sequenciador_multiciclo.sv
// Directed bench: default, zero-wait and narrow-counter instances.
module tb_sequenciador_multiciclo;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic mem_ready, step_en, step_req;

    // default instance
    logic        d_rst;
    logic [31:0] d_instr;
    logic [3:0]  d_estado;
    logic        d_if, d_id, d_ex, d_mem, d_wb, d_pc, d_fin, d_busy;
    logic [15:0] d_cyc, d_ins;

    // zero-wait instance
    logic        z_rst;
    logic [31:0] z_instr;
    logic [3:0]  z_estado;
    logic        z_if, z_id, z_ex, z_mem, z_wb, z_pc, z_fin, z_busy;
    logic [15:0] z_cyc, z_ins;

    // 4-bit counter instance
    logic        s_rst;
    logic [31:0] s_instr;
    logic [3:0]  s_estado;
    logic        s_if, s_id, s_ex, s_mem, s_wb, s_pc, s_fin, s_busy;
    logic [3:0]  s_cyc, s_ins;

    sequenciador_multiciclo u_def (
        .clk(clk), .rst(d_rst), .instrucao(d_instr), .mem_ready(mem_ready),
        .step_en(step_en), .step_req(step_req), .estado(d_estado),
        .if_en(d_if), .id_en(d_id), .ex_en(d_ex), .mem_en(d_mem), .wb_en(d_wb),
        .pc_en(d_pc), .finalizado(d_fin), .busy(d_busy),
        .cycle_count(d_cyc), .instr_count(d_ins)
    );

    sequenciador_multiciclo #(.EX_WAIT(0), .WB_WAIT(0)) u_zero (
        .clk(clk), .rst(z_rst), .instrucao(z_instr), .mem_ready(mem_ready),
        .step_en(step_en), .step_req(step_req), .estado(z_estado),
        .if_en(z_if), .id_en(z_id), .ex_en(z_ex), .mem_en(z_mem), .wb_en(z_wb),
        .pc_en(z_pc), .finalizado(z_fin), .busy(z_busy),
        .cycle_count(z_cyc), .instr_count(z_ins)
    );

    sequenciador_multiciclo #(.CNT_W(4)) u_sat (
        .clk(clk), .rst(s_rst), .instrucao(s_instr), .mem_ready(mem_ready),
        .step_en(step_en), .step_req(step_req), .estado(s_estado),
        .if_en(s_if), .id_en(s_id), .ex_en(s_ex), .mem_en(s_mem), .wb_en(s_wb),
        .pc_en(s_pc), .finalizado(s_fin), .busy(s_busy),
        .cycle_count(s_cyc), .instr_count(s_ins)
    );

    int total  = 0;
    int passed = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    typedef struct {
        logic [31:0] instr;
        logic        mr;
        logic [3:0]  est;
        logic [5:0]  en;   // {if,id,ex,mem,wb,pc}
        logic        fin;
    } vec_t;

    vec_t tabela[17];

    initial begin
        int first_fim, n, mcnt, wbcnt, nao_pausa, pcs;

        tabela[0]  = '{NOP,  1'b1, 4'd1, 6'b010000, 1'b0};
        tabela[1]  = '{NOP,  1'b1, 4'd2, 6'b001000, 1'b0};
        tabela[2]  = '{NOP,  1'b1, 4'd4, 6'b000100, 1'b0};
        tabela[3]  = '{NOP,  1'b1, 4'd5, 6'b000010, 1'b0};
        tabela[4]  = '{NOP,  1'b1, 4'd7, 6'b000001, 1'b0};
        tabela[5]  = '{NOP,  1'b1, 4'd0, 6'b100000, 1'b0};
        tabela[6]  = '{NOP,  1'b1, 4'd1, 6'b010000, 1'b0};
        tabela[7]  = '{NOP,  1'b1, 4'd2, 6'b001000, 1'b0};
        tabela[8]  = '{NOP,  1'b0, 4'd4, 6'b000100, 1'b0};
        tabela[9]  = '{NOP,  1'b0, 4'd4, 6'b000100, 1'b0};
        tabela[10] = '{NOP,  1'b0, 4'd4, 6'b000100, 1'b0};
        tabela[11] = '{NOP,  1'b1, 4'd5, 6'b000010, 1'b0};
        tabela[12] = '{NOP,  1'b1, 4'd7, 6'b000001, 1'b0};
        tabela[13] = '{NOP,  1'b1, 4'd0, 6'b100000, 1'b0};
        tabela[14] = '{NOP,  1'b1, 4'd1, 6'b010000, 1'b0};
        tabela[15] = '{32'h0, 1'b1, 4'd9, 6'b000000, 1'b1};
        tabela[16] = '{32'h0, 1'b1, 4'd9, 6'b000000, 1'b1};

        d_rst = 1'b0; z_rst = 1'b0; s_rst = 1'b0;
        d_instr = NOP; z_instr = NOP; s_instr = NOP;
        mem_ready = 1'b1; step_en = 1'b0; step_req = 1'b0;
        tick(2);

        // reset state
        chk("rst_estado", d_estado, 0);
        chk("rst_if_en", d_if, 1);
        chk("rst_final", d_fin, 0);
        chk("rst_busy", d_busy, 1);
        chk("rst_cycle", d_cyc, 0);
        chk("rst_instr", d_ins, 0);

        // one instruction then halt, default waits
        d_rst = 1'b1;
        first_fim = -1;
        for (int e = 1; e <= 40; e++) begin
            tick();
            if (e == 11) d_instr = 32'h0;
            if (d_fin && first_fim < 0) first_fim = e;
        end
        chk("halt_edge", first_fim, 16);
        chk("halt_final", d_fin, 1);
        chk("halt_busy", d_busy, 0);
        chk("halt_instr_cnt", d_ins, 1);
        chk("halt_cycle_frozen", d_cyc, 16);

        // MEM stalled for 4 cycles
        d_rst = 1'b0; d_instr = NOP; mem_ready = 1'b0;
        tick();
        d_rst = 1'b1;
        n = 0; mcnt = 0; wbcnt = 0;
        for (int e = 0; e < 40; e++) begin
            if (d_mem) mcnt++;
            mem_ready = d_mem && (mcnt >= 5);
            tick();
            n++;
            if (d_wb) wbcnt++;
            if (d_estado == 4'd0) break;
        end
        mem_ready = 1'b1;
        chk("stall_cost", n, 15);
        chk("stall_mem_cycles", mcnt, 5);
        chk("stall_wb_pulses", wbcnt, 1);

        // single-step mode
        d_rst = 1'b0; step_en = 1'b1;
        tick();
        d_rst = 1'b1;
        tick(3);
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        tick(7);
        chk("step_pause_estado", d_estado, 8);
        chk("step_pause_busy", d_busy, 0);
        nao_pausa = 0;
        for (int e = 0; e < 10; e++) begin
            tick();
            if (d_estado != 4'd8) nao_pausa++;
        end
        chk("step_hold", nao_pausa, 0);
        chk("step_instr_cnt", d_ins, 1);
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        chk("step_resume", d_estado, 0);
        tick(3);
        step_en = 1'b0;
        tick(8);
        chk("step_off_at_sumpc", d_estado, 0);
        chk("step_instr_cnt2", d_ins, 2);

        // async reset in EX_W
        d_rst = 1'b0;
        tick();
        d_rst = 1'b1;
        tick(3);
        chk("ar_in_exw", d_estado, 3);
        chk("ar_cycle_pre", d_cyc, 3);
        #1 d_rst = 1'b0;
        #1;
        chk("ar_estado", d_estado, 0);
        chk("ar_cycle", d_cyc, 0);
        chk("ar_instr", d_ins, 0);
        #1 d_rst = 1'b1;
        tick(11);
        chk("ar_fresh_estado", d_estado, 0);
        chk("ar_fresh_instr", d_ins, 1);
        chk("ar_fresh_cycle", d_cyc, 11);
        d_rst = 1'b0;

        // zero-wait table
        z_rst = 1'b1;
        for (int i = 0; i < 17; i++) begin
            z_instr   = tabela[i].instr;
            mem_ready = tabela[i].mr;
            tick();
            chk($sformatf("zw_estado[%0d]", i), z_estado, tabela[i].est);
            chk($sformatf("zw_en[%0d]", i),
                {z_if, z_id, z_ex, z_mem, z_wb, z_pc}, tabela[i].en);
            chk($sformatf("zw_final[%0d]", i), z_fin, tabela[i].fin);
            chk($sformatf("zw_busy[%0d]", i), z_busy, !tabela[i].fin);
        end
        mem_ready = 1'b1;
        chk("zw_instr_cnt", z_ins, 2);
        chk("zw_cycle_cnt", z_cyc, 16);
        z_rst = 1'b0;

        // saturating 4-bit counters over 20 instructions
        s_rst = 1'b1;
        pcs = 0;
        for (int e = 1; e <= 260; e++) begin
            tick();
            if (s_pc) pcs++;
            if (e == 220) s_instr = 32'h0;
            if (s_fin) break;
        end
        chk("sat_final", s_fin, 1);
        chk("sat_retired", pcs, 20);
        chk("sat_instr_cnt", s_ins, 15);
        chk("sat_cycle_cnt", s_cyc, 15);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
